// File: rtl/btb_setassoc.sv
// N-way set-associative branch target buffer with per-entry saturating direction counters.
// Same-cycle lookup for fetch, commit-time training, per-set round-robin victim choice.
module btb_setassoc #(
    parameter int SETS     = 32,
    parameter int WAYS     = 4,
    parameter int CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] fetch_pc,
    output logic        fetch_hit,
    output logic        fetch_taken,
    output logic [31:0] fetch_target,
    output logic [31:0] fetch_next_pc,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        commit_is_jump,
    input  logic        commit_is_branch,
    input  logic        commit_taken,
    input  logic [31:0] commit_target
);

    localparam int IDX_BITS = $clog2(SETS);
    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [CTR_BITS-1:0] CMAX = '1;
    localparam logic [CTR_BITS-1:0] WT   = {1'b1, {(CTR_BITS-1){1'b0}}};

    logic                valid_q  [SETS][WAYS];
    logic                valid_d  [SETS][WAYS];
    logic [TAG_BITS-1:0] tag_q    [SETS][WAYS];
    logic [TAG_BITS-1:0] tag_d    [SETS][WAYS];
    logic [31:0]         target_q [SETS][WAYS];
    logic [31:0]         target_d [SETS][WAYS];
    logic [CTR_BITS-1:0] ctr_q    [SETS][WAYS];
    logic [CTR_BITS-1:0] ctr_d    [SETS][WAYS];
    logic [WAY_W-1:0]    rr_q     [SETS];
    logic [WAY_W-1:0]    rr_d     [SETS];

    function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
        return (c == CMAX) ? c : c + CTR_BITS'(1);
    endfunction

    function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
        return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    function automatic logic [WAY_W-1:0] next_way(input logic [WAY_W-1:0] w);
        if (WAYS == 1) return '0;
        else           return w + WAY_W'(1);
    endfunction

    logic [IDX_BITS-1:0] f_set;
    logic [TAG_BITS-1:0] f_tag;
    logic [IDX_BITS-1:0] c_set;
    logic [TAG_BITS-1:0] c_tag;
    logic                unused_addr_bits;

    assign f_set = fetch_pc[IDX_BITS+1:2];
    assign f_tag = fetch_pc[31:IDX_BITS+2];
    assign c_set = commit_pc[IDX_BITS+1:2];
    assign c_tag = commit_pc[31:IDX_BITS+2];
    assign unused_addr_bits = ^{fetch_pc[1:0], commit_pc[1:0]};

    // Lookup: valid gates every term so don't-care contents of invalid ways never reach outputs.
    always_comb begin
        fetch_hit    = 1'b0;
        fetch_taken  = 1'b0;
        fetch_target = 32'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[f_set][w] && (tag_q[f_set][w] == f_tag)) begin
                fetch_hit    = 1'b1;
                fetch_taken  = fetch_taken | ctr_q[f_set][w][CTR_BITS-1];
                fetch_target = fetch_target | target_q[f_set][w];
            end
        end
    end

    assign fetch_next_pc = fetch_taken ? fetch_target : fetch_pc + 32'd4;

    logic             upd;
    logic             is_jump;
    logic             c_hit;
    logic [WAY_W-1:0] c_hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] victim;

    assign upd     = commit_valid && (commit_is_jump || commit_is_branch);
    assign is_jump = commit_is_jump;

    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        rr_d      = rr_q;
        c_hit     = 1'b0;
        c_hit_way = '0;
        inv_found = 1'b0;
        inv_way   = '0;

        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[c_set][w] && (tag_q[c_set][w] == c_tag)) begin
                c_hit     = 1'b1;
                c_hit_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_q[c_set][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : rr_q[c_set];

        // Flush wins over a same-cycle commit; the commit is simply dropped.
        if (flush) begin
            for (int s = 0; s < SETS; s++) begin
                rr_d[s] = '0;
                for (int w = 0; w < WAYS; w++) valid_d[s][w] = 1'b0;
            end
        end else if (upd) begin
            if (c_hit) begin
                if (is_jump) begin
                    ctr_d[c_set][c_hit_way]    = CMAX;
                    target_d[c_set][c_hit_way] = commit_target;
                end else if (commit_taken) begin
                    ctr_d[c_set][c_hit_way]    = sat_inc(ctr_q[c_set][c_hit_way]);
                    target_d[c_set][c_hit_way] = commit_target;
                end else begin
                    ctr_d[c_set][c_hit_way]    = sat_dec(ctr_q[c_set][c_hit_way]);
                end
                if (rr_q[c_set] == c_hit_way) rr_d[c_set] = next_way(rr_q[c_set]);
            end else if (is_jump || commit_taken) begin
                valid_d[c_set][victim]  = 1'b1;
                tag_d[c_set][victim]    = c_tag;
                target_d[c_set][victim] = commit_target;
                ctr_d[c_set][victim]    = is_jump ? CMAX : WT;
                if (!inv_found) rr_d[c_set] = next_way(rr_q[c_set]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
            end
        end else begin
            valid_q <= valid_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
    end

endmodule

// File: doc/btb_setassoc.md
Name: btb_setassoc

Overview:
Parametrised N-way set-associative branch target buffer with per-entry saturating direction counters and per-set round-robin replacement. It sits in the fetch stage. It gives a same-cycle prediction and next PC for the fetch PC. It is trained at commit by resolved jumps and branches from the ROB. It generalises the earlier 2-way, fixed-counter BTB with configurable sets, ways and counter width, target re-training, and a flush.

Parameters:
SETS, 32, number of sets; power of two, >=2
WAYS, 4, associativity; power of two, >=1
CTR_BITS, 2, width of each saturating direction counter; 2..4
IDX_BITS, $clog2(SETS), derived; not overridden
TAG_BITS, 30-IDX_BITS, derived; tag = pc[31:IDX_BITS+2]

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  invalidate all entries (e.g. context switch/fence.i)
fetch_pc  in  32  PC being fetched (word aligned)
fetch_hit  out  1  a valid way in set fetch_pc[IDX_BITS+1:2] matches tag
fetch_taken  out  1  predicted taken
fetch_target  out  32  stored target of hitting way (0 when no hit)
fetch_next_pc  out  32  fetch_taken ? fetch_target : fetch_pc+4
commit_valid  in  1  commit-side update strobe
commit_pc  in  32  PC of committing control-flow instruction
commit_is_jump  in  1  unconditional jump (jal)
commit_is_branch  in  1  conditional branch
commit_taken  in  1  resolved direction (branches)
commit_target  in  32  resolved target

Behaviour:
- State per (set,way): valid, tag[TAG_BITS], target[32], ctr[CTR_BITS]. Per set: rr_ptr[$clog2(WAYS)] (0-bit/unused when WAYS=1).
- CMAX = 2^CTR_BITS-1. WT = 2^(CTR_BITS-1) (weakly taken). Taken prediction = ctr MSB set.
- Lookup is purely combinational from the current state. With no hit: fetch_hit=0, fetch_taken=0, fetch_target=0, fetch_next_pc=fetch_pc+4 (mod 2^32).
- Allocation only happens on a miss, so at most one way can match. Outputs OR-reduce across ways.
- Update occurs when commit_valid && (commit_is_jump || commit_is_branch). If both flags are set, treat the instruction as a jump. Update writes land at the next posedge and are not visible to the lookup in the same cycle, including when fetch_pc==commit_pc.
- Hit, jump: ctr<=CMAX, target<=commit_target.
- Hit, taken branch: ctr<=min(ctr+1,CMAX), target<=commit_target.
- Hit, not-taken branch: ctr<=max(ctr-1,0), target unchanged, entry stays valid.
- Any hit: if rr_ptr[set]==hit way, then rr_ptr<=(rr_ptr+1) mod WAYS. This protects the MRU way.
- Miss, jump or taken branch: allocate the victim way and write valid=1, tag, target=commit_target, ctr=CMAX (jump) or WT (branch).
- Miss, not-taken branch: no state change.
- Victim selection: the lowest-index invalid way in the set. If all ways are valid, use way rr_ptr[set] and advance rr_ptr mod WAYS. Filling an invalid way leaves rr_ptr unchanged.
- flush or rst: clear all valid bits and all rr_ptr at the next posedge. Tag, target and ctr contents are don't-care. flush/rst override a same-cycle commit update, which is dropped.
- Reset values: storage as above. Outputs right after reset: fetch_hit=0, fetch_taken=0, fetch_target=0, fetch_next_pc=fetch_pc+4.
- Reset or flush asserted mid-stream takes effect at that edge only. There is no multi-cycle state machine, and the block is ready the following cycle.
- No X may propagate to outputs after reset, even from don't-care target/ctr of invalid ways.

Test Plan:
- Reset, then fetch_pc=0x0000_1000 -> hit=0, taken=0, next_pc=0x0000_1004. fetch_pc=0xFFFF_FFFC -> next_pc=0x0000_0000.
- Commit jump pc=0x1000, target=0x2000. Next cycle fetch 0x1000 -> hit=1, taken=1, next_pc=0x2000. In the commit cycle itself the lookup still reports hit=0.
- CTR_BITS=2: allocate taken branch pc=0x1040 -> ctr=2, taken. One not-taken commit -> ctr=1, hit=1, taken=0. Two not-taken -> ctr stays 0. Three taken -> ctr 3 and saturates.
- Not-taken branch miss at 0x1080 -> fetch 0x1080 hit=0. Taken branch hit with new target 0x3000 -> target updated to 0x3000.
- WAYS=4, SETS=32: commit 5 jumps mapping to set 0 (pc=0x000,0x080,0x100,0x180,0x200) -> first four fill ways 0-3. The fifth evicts way 0, so 0x000 misses and the rest hit. Then hit 0x080 (way 1, rr_ptr=1) -> rr_ptr becomes 2, and the next allocation evicts 0x100.
- Populate several entries, then assert flush together with commit_valid jump 0x1000 -> all fetches miss next cycle and 0x1000 is not installed.
